// File: rtl/phase2sample_interp_if.sv
// Bundles the phase/program request, ROM bus and sample result of phase2sample_interp.
// master drives requests and ROM data; slave (the stage) drives ROM addr and results.
interface phase2sample_interp_if #(
  parameter int PHASE_W  = 16,
  parameter int ADDR_W   = 6,
  parameter int SAMPLE_W = 8,
  parameter int PROG_W   = 7
);
  logic                     i_ce;
  logic [PHASE_W-1:0]       i_phase;
  logic [PROG_W-1:0]        i_program;
  logic                     o_rom_en;
  logic [PROG_W+ADDR_W-1:0] o_rom_addr;
  logic [SAMPLE_W-1:0]      i_rom_data;
  logic [SAMPLE_W-1:0]      o_sample_out;
  logic                     o_sample_valid;
  logic                     o_busy;
  logic                     o_overrun;

  modport master (
    output i_ce, i_phase, i_program, i_rom_data,
    input  o_rom_en, o_rom_addr, o_sample_out,
    input  o_sample_valid, o_busy, o_overrun
  );

  modport slave (
    input  i_ce, i_phase, i_program, i_rom_data,
    output o_rom_en, o_rom_addr, o_sample_out,
    output o_sample_valid, o_busy, o_overrun
  );
endinterface

// File: rtl/phase2sample_interp.sv
// Mirrored-wavetable phase-to-sample stage with linear interpolation.
// Ports: clk, rst_n (async low), bus (slave: ce/phase/program, ROM bus, sample out).
module phase2sample_interp #(
  parameter int PHASE_W   = 16,
  parameter int ADDR_W    = 6,
  parameter int FRAC_W    = 4,
  parameter int SAMPLE_W  = 8,
  parameter int PROG_W    = 7,
  parameter bit INTERP_EN = 1'b1
) (
  input logic clk,
  input logic rst_n,
  phase2sample_interp_if.slave bus
);

  localparam int K_W = ADDR_W + 1;
  localparam int D_W = SAMPLE_W + 1;
  localparam int P_W = D_W + FRAC_W + 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH_A = 3'd1;
  localparam logic [2:0] S_FETCH_B = 3'd2;
  localparam logic [2:0] S_WAIT_B  = 3'd3;
  localparam logic [2:0] S_INTERP  = 3'd4;

  logic [2:0]               r_state;
  logic [PROG_W+ADDR_W-1:0] r_addr;
  logic [PROG_W-1:0]        r_prog;
  logic                     r_ha;
  logic                     r_hb;
  logic [ADDR_W-1:0]        r_idxb;
  logic [FRAC_W-1:0]        r_frac;
  logic [SAMPLE_W-1:0]      r_a;
  logic [SAMPLE_W-1:0]      r_b;
  logic [SAMPLE_W-1:0]      r_out;
  logic                     r_valid;
  logic                     r_overrun;

  logic                     w_h;
  logic [ADDR_W-1:0]        w_idx;
  logic [FRAC_W-1:0]        w_frac;
  logic [K_W-1:0]           w_k;
  logic [K_W-1:0]           w_k1;
  logic                     w_idle;

  assign w_h    = bus.i_phase[PHASE_W-1];
  assign w_idx  = bus.i_phase[PHASE_W-2 -: ADDR_W];
  assign w_frac = bus.i_phase[PHASE_W-2-ADDR_W -: FRAC_W];
  assign w_k    = {w_h, w_idx};
  // Successor point wraps modulo 2N through the natural K_W-bit overflow.
  assign w_k1   = w_k + K_W'(1);
  assign w_idle = (r_state == S_IDLE);

  // Upper half reads the table backwards: 2N-1-k == ~idx within the half.
  logic [ADDR_W-1:0] w_addr_a;
  logic [ADDR_W-1:0] w_addr_b;
  assign w_addr_a = w_h  ? ~w_idx  : w_idx;
  assign w_addr_b = r_hb ? ~r_idxb : r_idxb;

  // Upper half also inverts the data: (2**SAMPLE_W-1) - x == ~x.
  logic [SAMPLE_W-1:0] w_data_a;
  logic [SAMPLE_W-1:0] w_data_b;
  assign w_data_a = r_ha ? ~bus.i_rom_data : bus.i_rom_data;
  assign w_data_b = r_hb ? ~bus.i_rom_data : bus.i_rom_data;

  logic signed [D_W-1:0] w_diff;
  logic signed [P_W-1:0] w_diff_x;
  logic signed [P_W-1:0] w_frac_x;
  logic signed [P_W-1:0] w_prod;
  logic signed [P_W-1:0] w_step;
  logic [SAMPLE_W-1:0]   w_interp;

  assign w_diff   = $signed({1'b0, r_b}) - $signed({1'b0, r_a});
  assign w_diff_x = P_W'(w_diff);
  assign w_frac_x = $signed({{(P_W-FRAC_W){1'b0}}, r_frac});
  assign w_prod   = w_diff_x * w_frac_x;
  // Arithmetic shift floors; result stays between a and b so the
  // low SAMPLE_W bits of a+step are exact.
  assign w_step   = w_prod >>> FRAC_W;
  assign w_interp = r_a + w_step[SAMPLE_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_prog    <= '0;
      r_ha      <= 1'b0;
      r_hb      <= 1'b0;
      r_idxb    <= '0;
      r_frac    <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_out     <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (bus.i_ce && !w_idle)
        r_overrun <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (bus.i_ce) begin
            r_prog  <= bus.i_program;
            r_ha    <= w_h;
            r_hb    <= w_k1[K_W-1];
            r_idxb  <= w_k1[ADDR_W-1:0];
            r_frac  <= w_frac;
            r_addr  <= {bus.i_program, w_addr_a};
            r_state <= S_FETCH_A;
          end
        end
        S_FETCH_A: begin
          r_addr  <= {r_prog, w_addr_b};
          r_state <= S_FETCH_B;
        end
        S_FETCH_B: begin
          r_a     <= w_data_a;
          r_state <= S_WAIT_B;
        end
        S_WAIT_B: begin
          r_b     <= w_data_b;
          r_state <= S_INTERP;
        end
        S_INTERP: begin
          r_out   <= INTERP_EN ? w_interp : r_a;
          r_valid <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.o_rom_en       = (r_state == S_FETCH_A) ||
                              (r_state == S_FETCH_B);
  assign bus.o_rom_addr     = r_addr;
  assign bus.o_sample_out   = r_out;
  assign bus.o_sample_valid = r_valid;
  assign bus.o_busy         = !w_idle;
  assign bus.o_overrun      = r_overrun;

endmodule

// File: tb/tb_phase2sample_interp.sv
// Directed bench for phase2sample_interp with a rom[p][a]=4*a model.
// Checks reset, interpolation, half/wrap boundaries, overrun and mid-op reset.
module tb_phase2sample_interp;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  int   pulses;
  logic [12:0] addr_q[$];

  phase2sample_interp_if #(
    .PHASE_W(16), .ADDR_W(6), .SAMPLE_W(8), .PROG_W(7)
  ) bus ();

  phase2sample_interp #(
    .PHASE_W(16), .ADDR_W(6), .FRAC_W(4),
    .SAMPLE_W(8), .PROG_W(7), .INTERP_EN(1'b1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.o_rom_en) begin
      bus.i_rom_data <= {bus.o_rom_addr[5:0], 2'b00};
      addr_q.push_back(bus.o_rom_addr);
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic start(input logic [15:0] ph,
                       input logic [6:0] pg);
    @(negedge clk);
    bus.i_ce      = 1'b1;
    bus.i_phase   = ph;
    bus.i_program = pg;
    @(posedge clk);
    #1;
    bus.i_ce = 1'b0;
  endtask

  task automatic run_op(input string tag,
                        input logic [15:0] ph,
                        input logic [6:0] pg,
                        input logic [5:0] ea,
                        input logic [5:0] eb,
                        input logic [7:0] eo);
    addr_q.delete();
    start(ph, pg);
    check({tag, ".busy"}, 32'(bus.o_busy), 32'd1);
    // Scramble inputs: the op in flight must not see this.
    bus.i_phase   = 16'h0000;
    bus.i_program = 7'h00;
    repeat (3) @(posedge clk);
    #1;
    check({tag, ".early"}, 32'(bus.o_sample_valid), 32'd0);
    @(posedge clk);
    #1;
    check({tag, ".valid"}, 32'(bus.o_sample_valid), 32'd1);
    check({tag, ".out"}, 32'(bus.o_sample_out), 32'(eo));
    check({tag, ".naddr"}, 32'(addr_q.size()), 32'd2);
    if (addr_q.size() == 2) begin
      check({tag, ".addr_a"}, 32'(addr_q[0]), 32'({pg, ea}));
      check({tag, ".addr_b"}, 32'(addr_q[1]), 32'({pg, eb}));
    end
    @(posedge clk);
    #1;
    check({tag, ".pulse"}, 32'(bus.o_sample_valid), 32'd0);
    check({tag, ".idle"}, 32'(bus.o_busy), 32'd0);
  endtask

  initial begin
    n_tests        = 0;
    n_fail         = 0;
    rst_n          = 1'b0;
    bus.i_ce       = 1'b0;
    bus.i_phase    = '0;
    bus.i_program  = '0;
    bus.i_rom_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.out", 32'(bus.o_sample_out), 32'd0);
    check("rst.valid", 32'(bus.o_sample_valid), 32'd0);
    check("rst.busy", 32'(bus.o_busy), 32'd0);
    check("rst.rom_en", 32'(bus.o_rom_en), 32'd0);
    check("rst.overrun", 32'(bus.o_overrun), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("basic", 16'h1500, 7'h05, 6'd10, 6'd11, 8'd42);
    run_op("frac0", 16'h1400, 7'h11, 6'd10, 6'd11, 8'd40);
    run_op("half", 16'h7F00, 7'h22, 6'd63, 6'd63, 8'd127);
    run_op("wrap", 16'hFE80, 7'h7F, 6'd0, 6'd0, 8'd191);
    run_op("upper", 16'h81E0, 7'h01, 6'd63, 6'd62, 8'd6);
    check("no_overrun", 32'(bus.o_overrun), 32'd0);

    // Second ce two clocks after the first lands mid-op.
    start(16'h1500, 7'h05);
    @(posedge clk);
    #1;
    bus.i_ce    = 1'b1;
    bus.i_phase = 16'h0000;
    @(posedge clk);
    #1;
    bus.i_ce = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("ovr.valid", 32'(bus.o_sample_valid), 32'd1);
    check("ovr.out", 32'(bus.o_sample_out), 32'd42);
    check("ovr.flag", 32'(bus.o_overrun), 32'd1);
    repeat (4) @(posedge clk);
    #1;
    check("ovr.sticky", 32'(bus.o_overrun), 32'd1);
    check("ovr.idle", 32'(bus.o_busy), 32'd0);

    // Reset while in FETCH_B.
    start(16'h7F00, 7'h03);
    @(posedge clk);
    #1;
    check("mid.busy", 32'(bus.o_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid.out", 32'(bus.o_sample_out), 32'd0);
    check("mid.busy0", 32'(bus.o_busy), 32'd0);
    check("mid.overrun", 32'(bus.o_overrun), 32'd0);
    check("mid.rom_en", 32'(bus.o_rom_en), 32'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (bus.o_sample_valid) pulses++;
    end
    check("mid.nopulse", 32'(pulses), 32'd0);
    check("mid.hold", 32'(bus.o_sample_out), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
